// File: rtl/pc_lut_loader_pkg.sv
// Shared definitions for the PC/constant lookup-table loader: FSM states,
// table geometry and the helper that flags hi-byte bits the entry cannot hold.
package pc_lut_loader_pkg;

    localparam int LUT_D       = 12;
    localparam int LUT_A       = 5;
    localparam int LUT_DEPTH   = 1 << LUT_A;
    localparam int HALT_TARGET = 511;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_FIN
    } state_e;

    // Bits of the hi byte that fall above the D-bit entry; all-zero when D == 16.
    function automatic logic [7:0] hi_excess_mask(input int d);
        return 8'hFF << (d - 8);
    endfunction

endpackage

// File: rtl/pc_lut_loader.sv
// Writer side of the jump/constant table: assembles D-bit entries from lo/hi
// byte pairs and drives the table write port, one entry every three cycles.
module pc_lut_loader
    import pc_lut_loader_pkg::*;
#(
    parameter int D = LUT_D,
    parameter int A = LUT_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] start_idx,
    input  logic [A:0]   count,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [A-1:0] wr_addr,
    output logic [D-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [7:0] HI_EXCESS = hi_excess_mask(D);

    state_e         state_q;
    logic [A-1:0]   idx_q;
    logic [A:0]     rem_q;
    logic [7:0]     lo_q;
    logic           in_ready_q;
    logic           wr_en_q;
    logic [A-1:0]   wr_addr_q;
    logic [D-1:0]   wr_data_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           byte_take;

    assign byte_take = in_valid && in_ready_q;

    // Every output is a register loaded alongside the state it belongs to,
    // so in_ready never depends combinationally on in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            lo_q       <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout: every right-hand side
            // reads the pre-edge register values, independent of statement order.
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q <= start_idx;
                        rem_q <= count;
                        err_q <= 1'b0;
                        if (count != '0) begin
                            state_q    <= ST_LO;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    if (byte_take) begin
                        lo_q    <= in_data;
                        state_q <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (byte_take) begin
                        // Excess hi bits are dropped by the truncation but reported.
                        wr_data_q  <= D'({in_data, lo_q});
                        wr_addr_q  <= idx_q;
                        wr_en_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        if ((in_data & HI_EXCESS) != 8'h00) begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    idx_q <= idx_q + A'(1);
                    rem_q <= rem_q - (A+1)'(1);
                    if (rem_q == (A+1)'(1)) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= ST_LO;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pc_lut_loader.sv
// Self-checking bench for pc_lut_loader: directed boot-load scenarios followed
// by randomized loads, compared against a table-level model of the loads.
module tb_pc_lut_loader;

    localparam int D     = 12;
    localparam int A     = 5;
    localparam int DEPTH = 1 << A;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [A-1:0] start_idx;
    logic [A:0]   count;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    // Source bytes for the next load, lo byte first for each entry.
    int src_q[$];

    pc_lut_loader #(.D(D), .A(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int cnt, input int excess_pct);
        src_q.delete();
        for (int k = 0; k < cnt; k++) begin
            src_q.push_back(int'($urandom_range(0, 255)));
            if (int'($urandom_range(0, 99)) < excess_pct)
                src_q.push_back(int'($urandom_range(16, 255)));
            else
                src_q.push_back(int'($urandom_range(0, 15)));
        end
    endtask

    // vmode: 0 = in_valid held high, 1 = toggled each cycle, 2 = random.
    // Starts one load from src_q, tracks the handshake and compares the
    // observed write stream against the table-level expectation.
    task automatic run_load(input int sidx, input int cnt, input int vmode, input bit spurious);
        int  exp_addr[$];
        int  exp_data[$];
        int  got_addr[$];
        int  got_data[$];
        bit  exp_err    = 1'b0;
        int  ptr        = 0;
        int  t          = 0;
        int  first_wr   = -1;
        int  last_wr    = -1;
        int  done_t     = -1;
        int  n_done     = 0;
        int  budget     = 40 + 12 * cnt;
        bit  busy_seen  = 1'b0;
        bit  ready_in_wr = 1'b0;
        int  n_cmpw;

        for (int k = 0; k < cnt; k++) begin
            int lo = src_q[2*k];
            int hi = src_q[2*k+1];
            exp_addr.push_back((sidx + k) % DEPTH);
            exp_data.push_back((hi * 256 + lo) % (1 << D));
            if (hi >= (1 << (D - 8))) exp_err = 1'b1;
        end

        @(negedge clk);
        start     = 1'b1;
        start_idx = sidx[A-1:0];
        count     = cnt[A:0];
        in_valid  = 1'b0;

        while (t < budget) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            if (t == 1) begin
                check("busy_after_start", busy, (cnt != 0));
                check("err_clear_on_start", err, 0);
            end
            if (busy) busy_seen = 1'b1;
            if (wr_en) begin
                got_addr.push_back(int'(wr_addr));
                got_data.push_back(int'(wr_data));
                if (first_wr < 0) first_wr = t;
                last_wr = t;
                if (in_ready) ready_in_wr = 1'b1;
            end
            if (done) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
            if (done_t >= 0 && t >= done_t + 3) break;

            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = t[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (in_valid && ptr < src_q.size()) in_data = 8'(src_q[ptr]);
            else                                in_data = 8'($urandom_range(0, 255));
            if (in_valid && in_ready) ptr++;
            if (spurious && busy && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                start_idx = A'($urandom_range(0, DEPTH - 1));
                count     = (A+1)'($urandom_range(0, DEPTH));
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;

        check("done_seen", (done_t >= 0), 1);
        check("done_pulses", n_done, 1);
        check("write_count", got_addr.size(), cnt);
        n_cmpw = (got_addr.size() < cnt) ? got_addr.size() : cnt;
        for (int k = 0; k < n_cmpw; k++) begin
            check($sformatf("wr_addr[%0d]", k), got_addr[k], exp_addr[k]);
            check($sformatf("wr_data[%0d]", k), got_data[k], exp_data[k]);
        end
        check("bytes_consumed", ptr, 2 * cnt);
        check("err_after_load", err, exp_err);
        check("idle_not_busy", busy, 0);
        if (cnt > 0) begin
            check("done_after_last_wr", done_t - last_wr, 1);
            check("in_ready_low_in_write", ready_in_wr, 0);
            if (vmode == 0) begin
                check("start_to_first_wr", first_wr, 3);
                check("entry_period", last_wr - first_wr, 3 * (cnt - 1));
            end
        end else begin
            check("zero_count_busy", busy_seen, 0);
            check("zero_count_done_window", (done_t >= 1 && done_t <= 2), 1);
        end
    endtask

    initial begin
        bit saw_done;
        bit saw_wr;

        reset     = 1'b1;
        start     = 1'b0;
        start_idx = '0;
        count     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two entries back to back from index 10.
        src_q = '{8'h0F, 8'h00, 8'h16, 8'h00};
        run_load(10, 2, 0, 1'b0);

        // Single entry with in_valid toggling every cycle.
        src_q = '{8'hA5, 8'h0C};
        run_load(7, 1, 1, 1'b0);

        // Index wraps from the last table slot to slot 0.
        src_q = '{8'h34, 8'h02, 8'h78, 8'h05};
        run_load(31, 2, 0, 1'b0);

        // Oversized hi byte: entry truncated, err sticky until the next start.
        src_q = '{8'hFF, 8'hF1};
        run_load(3, 1, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("err_sticky_idle", err, 1);

        // Empty load; its start also clears the sticky err.
        src_q.delete();
        run_load(12, 0, 0, 1'b0);

        // Reset while waiting for the hi byte.
        src_q = '{8'h11, 8'h03};
        @(negedge clk);
        start     = 1'b1;
        start_idx = A'(20);
        count     = (A+1)'(1);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        check("hi_wait_ready", in_ready, 1);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_done", done, 0);
        reset    = 1'b0;
        saw_done = 1'b0;
        saw_wr   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done)  saw_done = 1'b1;
            if (wr_en) saw_wr   = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        check("midrst_no_wr", saw_wr, 0);
        src_q = '{8'h22, 8'h04};
        run_load(20, 1, 0, 1'b0);

        // Randomized loads, including a full-table load and ignored starts.
        for (int r = 0; r < 24; r++) begin
            int cnt;
            int vm;
            cnt = (r % 8 == 7) ? DEPTH : int'($urandom_range(1, 8));
            vm  = int'($urandom_range(0, 2));
            fill_random(cnt, 20);
            run_load(int'($urandom_range(0, DEPTH - 1)), cnt, vm, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
